// File: rtl/serv_mdu_iter.sv
// Iterative RV32M multiply/divide unit for the serv extension port.
// One radix-2 step per cycle; every operation takes 33 cycles from accept to ready.
module serv_mdu_iter #(
    parameter int MDU_DIV = 1
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_mdu_valid,
    input  logic [2:0]  i_mdu_op,
    input  logic [31:0] i_mdu_rs1,
    input  logic [31:0] i_mdu_rs2,
    output logic [31:0] o_mdu_rd,
    output logic        o_mdu_ready
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, WAIT} state_t;

    state_t      state;
    logic [2:0]  op;
    logic        sign_a;
    logic        sign_b;
    logic        div0;
    logic [4:0]  cnt;
    logic [31:0] opa;      // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [31:0] opb;      // |b|
    logic [31:0] rs1_lat;
    logic [63:0] acc;      // product, or partial remainder in acc[32:0]

    logic        signed_a_in;
    logic        signed_b_in;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_ok;
    logic [63:0] prod;
    logic [31:0] fix_res;

    function automatic logic [31:0] neg32(input logic signed [31:0] v);
        return 32'(-v);
    endfunction

    function automatic logic [63:0] neg64(input logic signed [63:0] v);
        return 64'(-v);
    endfunction

    // Negating 0x80000000 wraps to itself, which read unsigned is 2^31.
    function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic neg);
        return neg ? neg32(v) : 32'(v);
    endfunction

    always_comb begin
        signed_a_in = (i_mdu_op == 3'd1) || (i_mdu_op == 3'd2) ||
                      (i_mdu_op == 3'd4) || (i_mdu_op == 3'd6);
        signed_b_in = (i_mdu_op == 3'd1) || (i_mdu_op == 3'd4) || (i_mdu_op == 3'd6);

        mul_sum   = {1'b0, acc[63:32]} + (opa[0] ? {1'b0, opb} : 33'd0);
        div_shift = {acc[31:0], opa[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
        div_ok    = ~div_diff[33];

        prod = (sign_a ^ sign_b) ? neg64(acc) : acc;

        fix_res = 32'd0;
        case (op)
            3'd0:          fix_res = prod[31:0];
            3'd1, 3'd2, 3'd3: fix_res = prod[63:32];
            3'd4, 3'd5:    fix_res = div0 ? 32'hFFFF_FFFF :
                                     ((sign_a ^ sign_b) ? neg32(opa) : opa);
            default:       fix_res = div0 ? rs1_lat :
                                     (sign_a ? neg32(acc[31:0]) : acc[31:0]);
        endcase
        if (MDU_DIV == 0 && op[2])
            fix_res = 32'd0;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            op          <= 3'd0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            div0        <= 1'b0;
            cnt         <= 5'd0;
            opa         <= 32'd0;
            opb         <= 32'd0;
            rs1_lat     <= 32'd0;
            acc         <= 64'd0;
            o_mdu_rd    <= 32'd0;
            o_mdu_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_mdu_valid) begin
                        op      <= i_mdu_op;
                        sign_a  <= i_mdu_rs1[31] & signed_a_in;
                        sign_b  <= i_mdu_rs2[31] & signed_b_in;
                        opa     <= mag32(i_mdu_rs1, i_mdu_rs1[31] & signed_a_in);
                        opb     <= mag32(i_mdu_rs2, i_mdu_rs2[31] & signed_b_in);
                        rs1_lat <= i_mdu_rs1;
                        acc     <= 64'd0;
                        div0    <= (i_mdu_rs2 == 32'd0);
                        cnt     <= 5'd0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (!op[2]) begin
                        acc <= {mul_sum, acc[31:1]};
                        opa <= {1'b0, opa[31:1]};
                    end else begin
                        acc <= {31'd0, div_ok ? div_diff[32:0] : div_shift};
                        opa <= {opa[30:0], div_ok};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    o_mdu_rd    <= fix_res;
                    o_mdu_ready <= 1'b1;
                    state       <= WAIT;
                end
                WAIT: begin
                    // A valid still held from the finished request must not re-issue.
                    o_mdu_ready <= 1'b0;
                    if (!i_mdu_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serv_mdu_iter.sv
// Bench for serv_mdu_iter: directed and random RV32M ops against an arithmetic model,
// with a second instance built without divide support.
module tb_serv_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic [31:0] rd_nd;
    logic        rdy;
    logic        rdy_nd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serv_mdu_iter #(.MDU_DIV(1)) dut (
        .clk(clk), .i_rst(rst), .i_mdu_valid(valid), .i_mdu_op(op),
        .i_mdu_rs1(rs1), .i_mdu_rs2(rs2), .o_mdu_rd(rd), .o_mdu_ready(rdy)
    );

    serv_mdu_iter #(.MDU_DIV(0)) dut_nd (
        .clk(clk), .i_rst(rst), .i_mdu_valid(valid), .i_mdu_op(op),
        .i_mdu_rs1(rs1), .i_mdu_rs2(rs2), .o_mdu_rd(rd_nd), .o_mdu_ready(rdy_nd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics computed with wide integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input bit div_en);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        if (f[2] && !div_en) return 32'd0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
        logic [31:0] exp, exp_nd;
        int          cyc;
        bit          got;
        exp    = model(f, a, b, 1'b1);
        exp_nd = model(f, a, b, 1'b0);
        @(negedge clk);
        valid = 1'b1; op = f; rs1 = a; rs2 = b;
        @(posedge clk);
        @(negedge clk);
        // operands only matter on the accept edge
        rs1 = $urandom; rs2 = $urandom; op = 3'($urandom_range(0, 7));
        cyc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (rdy) got = 1'b1;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd33);
        chk({tag, "_rd"}, rd, exp);
        chk({tag, "_nd_ready"}, {31'd0, rdy_nd}, 32'd1);
        chk({tag, "_nd_rd"}, rd_nd, exp_nd);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_ready"}, {31'd0, rdy}, 32'd0);
        end
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ready_low"}, {31'd0, rdy | rdy_nd}, 32'd0);
        chk({tag, "_rd_hold"}, rd, exp);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", rd, 32'd0);
        chk("reset_ready", {31'd0, rdy}, 32'd0);
        chk("reset_rd_nd", rd_nd, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("mul",      3'd0, 32'd7,          32'hFFFF_FFFD, 0);
        run("mulhu",    3'd3, 32'd7,          32'hFFFF_FFFD, 0);
        run("mulh_min", 3'd1, 32'h8000_0000,  32'h8000_0000, 1);
        run("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run("div",      3'd4, 32'hFFFF_FFF9,  32'd2,         0);
        run("rem",      3'd6, 32'hFFFF_FFF9,  32'd2,         0);
        run("divu",     3'd5, 32'hFFFF_FFFF,  32'h10,        0);
        run("div0",     3'd4, 32'd5,          32'd0,         0);
        run("divu0",    3'd5, 32'd5,          32'd0,         0);
        run("rem0",     3'd6, 32'hFFFF_FFFB,  32'd0,         0);
        run("remu0",    3'd7, 32'd5,          32'd0,         0);
        run("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run("hold3",    3'd0, 32'h1234_5678,  32'h9ABC_DEF0, 3);
        run("div_9_3",  3'd4, 32'd9,          32'd3,         0);

        // abort mid-CALC: rd currently holds 3, must clear immediately
        @(negedge clk);
        valid = 1'b1; op = 3'd0; rs1 = 32'd11; rs2 = 32'd13;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, rdy}, 32'd0);
        chk("abort_rd", rd, 32'd0);
        chk("abort_rd_nd", rd_nd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_strobe", {31'd0, rdy | rdy_nd}, 32'd0);
        run("after_abort", 3'd6, 32'd100, 32'd7, 0);

        for (int n = 0; n < 16; n++) begin
            logic [31:0] a, b;
            logic [2:0]  f;
            a = $urandom;
            b = $urandom;
            f = 3'($urandom_range(0, 7));
            if (n % 5 == 1) b = 32'd0;
            if (n % 5 == 2) b = {28'd0, b[3:0]} | 32'd1;
            if (n % 5 == 3) a = 32'h8000_0000;
            run("rand", f, a, b, n % 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serv_mdu_iter.md
# serv_mdu_iter

Iterative RV32M multiply/divide unit on the serv_top extension port. It consumes `o_ext_rs1`, `o_ext_rs2`, `o_ext_funct3` and `o_mdu_valid`, and returns `i_ext_rd` and `i_ext_ready`. It computes one radix-2 step per cycle over 32 cycles, so every operation has the same fixed latency.

## Interface
Parameters:
- `MDU_DIV`, default 1: 1 = full M extension; 0 = divide ops (funct3[2]=1) return 0x00000000 with unchanged latency.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_mdu_valid`  in  1  request from `o_mdu_valid`; level, held until ready is seen.
- `i_mdu_op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `i_mdu_rs1`  in  32  operand a (from `o_ext_rs1`).
- `i_mdu_rs2`  in  32  operand b (from `o_ext_rs2`).
- `o_mdu_rd`  out  32  result (to `i_ext_rd`); holds until the next accept.
- `o_mdu_ready`  out  1  one-cycle completion strobe (to `i_ext_ready`).

## Operation
States: IDLE, CALC, FIX, WAIT. Reset state is IDLE.

Reset values: `o_mdu_ready`=0, `o_mdu_rd`=0, 5-bit step counter=0, and all datapath registers 0. Asserting `i_rst` mid-operation aborts it with no ready strobe.

- **IDLE:** if `i_mdu_valid`=1, accept:
  - Latch op.
  - Latch sign_a = rs1[31] & signed_a, where signed_a is set for MULH, MULHSU, DIV, REM.
  - Latch sign_b = rs2[31] & signed_b, where signed_b is set for MULH, DIV, REM.
  - Load magnitudes |a| and |b| as 32-bit unsigned; the magnitude of 0x80000000 is 2^31.
  - Clear the counter, flag div0 = (rs2==0), then go to CALC.
- **CALC (multiply):** 64-bit shift-add of |a|·|b|, one multiplier bit per cycle, LSB first.
- **CALC (divide):** restoring division of |a| by |b|, one quotient bit per cycle, MSB first. Partial remainder is 33 bits; the trial subtract sets the quotient bit when there is no borrow.
- **CALC exit:** the counter increments each cycle; after the 32nd step (counter wrap 31→0) go to FIX.
- **FIX (multiply):** P = product, negated (64-bit two's complement) if sign_a^sign_b. MUL→P[31:0]; MULH/MULHSU/MULHU→P[63:32].
- **FIX (quotient):** DIV/DIVU → q, negated if sign_a^sign_b.
  - If div0, q=0xFFFFFFFF instead.
  - Overflow needs no special case: 0x80000000 / -1 yields 0x80000000.
- **FIX (remainder):** REM/REMU → r, negated if sign_a.
  - If div0, r=rs1 as latched (original value, not the magnitude).
  - Overflow remainder is 0.
- **FIX exit:** register `o_mdu_rd`, set `o_mdu_ready`=1, go to WAIT.
- **WAIT:** `o_mdu_ready` returns to 0 after one cycle. Stay in WAIT while `i_mdu_valid`=1; go to IDLE on the first cycle it is 0. This prevents a stale valid from double-issuing.
- **Operand stability:** `i_mdu_valid`, op and operands are ignored outside IDLE. Operands need only be stable on the accept cycle.

## Timing
- Accept edge = E0 (IDLE with valid=1).
- CALC occupies edges E1..E32; FIX registers the result at E33.
- `o_mdu_ready` is high exactly during the cycle after E33.
- Latency from accept edge to ready high is 33 cycles, identical for all ops including div0 and overflow.
- Earliest next accept: the edge after valid is sampled low in WAIT.
- Throughput: at most one op per 35 cycles.
- `o_mdu_rd` changes only at FIX edges and on reset.

## Test plan
- MUL 7·(−3), i.e. rs1=7, rs2=0xFFFFFFFD, op 0 → ready 33 cycles after accept, rd=0xFFFFFFEB. MULHU same operands → rd=0x00000006.
- MULH 0x80000000·0x80000000 → rd=0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → rd=0xFFFFFFFF.
- DIV −7/2 → rd=0xFFFFFFFD. REM −7/2 → rd=0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 → rd=0x0FFFFFFF.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF; DIVU 5/0 → 0xFFFFFFFF.
  - REM −5/0 → 0xFFFFFFFB; REMU 5/0 → 0x00000005.
  - Latency is still 33 cycles.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Handshake:
  - Holding valid high 3 extra cycles after ready produces exactly one ready pulse; new operands presented then are ignored.
  - Asserting `i_rst` at cycle 10 of CALC makes ready=0 and rd=0 immediately; a fresh op afterwards returns a correct result.
  - With `MDU_DIV`=0, DIV 9/3 → rd=0 at 33 cycles.
